fetch_unit: RTL and testbench

Instruction fetch stage for the shrv32 core. Owns the program counter, drives the instruction ROM address, and absorbs the ROM's one-cycle synchronous read latency. Delivers `{pc, inst}` packets to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and discards any wrong-path fetch in flight.

---
 rtl/shrv32_pkg.sv | 19 +
 rtl/fetch_hold_buf.sv | 30 +++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shrv32_pkg.sv
// Shared shrv32 types and constants for the fetch slice.
// Holds the fetch packet layout, the reset vector and the word-alignment helper.
package shrv32_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold register that parks a fetched packet while decode stalls.
// Latency: loads on the clock edge; flush has priority over load, and load has priority over consume.
module fetch_hold_buf
  import shrv32_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  fetch_pkt_t load_pkt,
  input  logic       consume,
  input  logic       flush,
  output logic       valid,
  output fetch_pkt_t pkt
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
      pkt   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pkt   <= load_pkt;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// shrv32 fetch stage: owns the PC, hides the 1-cycle ROM latency and feeds decode over valid/ready.
// First packet arrives 1 cycle after the first issue; stalls park the word in the hold buffer without bubbles.
// FETCH_REDIRECT_BYPASS_EN: the redirect target drives the ROM in the redirect cycle itself (1-cycle penalty).
module fetch_unit
  import shrv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] target;
  logic            pend_valid;
  logic            hold_valid;
  logic            out_valid_raw;
  logic            issue;
  logic            stall;
  logic            consume_hold;
  fetch_pkt_t      hold_pkt;
  fetch_pkt_t      pend_pkt;
  fetch_pkt_t      sel_pkt;

  assign target        = word_align(redirect_pc);
  assign out_valid_raw = hold_valid | pend_valid;
  assign out_valid     = out_valid_raw & ~redirect_valid;
  assign issue         = ~out_valid_raw | out_ready;
  assign stall         = pend_valid & ~hold_valid & ~out_ready;
  assign consume_hold  = out_valid & out_ready & hold_valid;

  assign pend_pkt = '{pc: pend_pc, inst: imem_rdata};
  assign sel_pkt  = hold_valid ? hold_pkt : pend_pkt;
  assign out_pc   = out_valid ? sel_pkt.pc   : '0;
  assign out_inst = out_valid ? sel_pkt.inst : '0;

`ifdef FETCH_REDIRECT_BYPASS_EN
  assign imem_addr = (redirect_valid & ~RST) ? target : fetch_pc;
`else
  assign imem_addr = fetch_pc;
`endif

  fetch_hold_buf u_hold (
    .CLK      (CLK),
    .RST      (RST),
    .load     (stall),
    .load_pkt (pend_pkt),
    .consume  (consume_hold),
    .flush    (redirect_valid),
    .valid    (hold_valid),
    .pkt      (hold_pkt)
  );

  // A redirect kills the in-flight request; the ROM word it returns next cycle is never presented.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc   <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (redirect_valid) begin
`ifdef FETCH_REDIRECT_BYPASS_EN
      pend_valid <= 1'b1;
      pend_pc    <= target;
      fetch_pc   <= target + 32'd4;
`else
      pend_valid <= 1'b0;
      fetch_pc   <= target;
`endif
    end else if (issue) begin
      pend_valid <= 1'b1;
      pend_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + 32'd4;
    end else if (stall) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected packets are queued with the stimulus and popped on each handshake.
module tb_fetch_unit;
  import shrv32_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;

  logic [31:0] addr2, rdata2, pc2, inst2;
  logic        ov2;
  logic        rdy2 = 1'b1;
  logic        rv2 = 1'b0;
  logic [31:0] rpc2 = '0;

  int total = 0;
  int bad = 0;
  fetch_pkt_t exp_q[$];
  fetch_pkt_t exp2_q[$];
  fetch_pkt_t e;

`ifdef FETCH_REDIRECT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST), .imem_addr(addr2), .imem_rdata(rdata2),
    .redirect_valid(rv2), .redirect_pc(rpc2),
    .out_valid(ov2), .out_ready(rdy2), .out_pc(pc2), .out_inst(inst2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0430_0193;
      32'h4:   return 32'h0020_0113;
      32'h8:   return 32'h2000_0083;
      default: return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endcase
  endfunction

  function automatic fetch_pkt_t mk(input logic [31:0] a);
    return '{pc: a, inst: rom_word(a)};
  endfunction

  // Synchronous ROMs: address registered, word returned the following cycle.
  always @(posedge CLK) begin
    imem_rdata <= rom_word(imem_addr);
    rdata2     <= rom_word(addr2);
  end

  a_hold_pend_excl: assert property (@(posedge CLK) disable iff (RST)
    !(dut.hold_valid && dut.pend_valid));

  task automatic apply_reset();
    RST = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h want 0", out_inst); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    total++; if (addr2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_addr2: got %h want fffffff8", addr2); end
    total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rst_valid2: got %b want 0", ov2); end
    @(posedge CLK); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_stream();
    exp_q.delete(); exp2_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(32'(4 * i)));
    for (int i = 0; i < 6; i++) exp2_q.push_back(mk(32'hFFFF_FFF8 + 32'(4 * i)));
    out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_latency: got valid=%b at c0 want 0", out_valid); end
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL first_latency2: got valid=%b at c0 want 0", ov2); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h want no packet", out_pc); end
        else begin
          e = exp_q.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst) begin
            bad++; $display("FAIL stream_pkt c%0d: got %h/%h want %h/%h", c, out_pc, out_inst, e.pc, e.inst);
          end
        end
      end
      if (ov2 && rdy2) begin
        total++;
        if (exp2_q.size() == 0) begin bad++; $display("FAIL wrap_extra: got pc=%h want no packet", pc2); end
        else begin
          e = exp2_q.pop_front();
          if (pc2 !== e.pc || inst2 !== e.inst) begin
            bad++; $display("FAIL wrap_pkt c%0d: got %h/%h want %h/%h", c, pc2, inst2, e.pc, e.inst);
          end
        end
      end
      @(posedge CLK); #1;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_missing: got %0d left want 0", exp_q.size()); end
    total++; if (exp2_q.size() != 0) begin bad++; $display("FAIL wrap_missing: got %0d left want 0", exp2_q.size()); end
  endtask

  task automatic test_stall();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(32'(4 * i)));
    out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (c >= 2 && c <= 4) begin
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'h0020_0113) begin
          bad++; $display("FAIL stall_present c%0d: got %b %h/%h want 1 4/00200113", c, out_valid, out_pc, out_inst);
        end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr c%0d: got %h want 8", c, imem_addr); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL stall_extra: got pc=%h want no packet", out_pc); end
        else begin
          e = exp_q.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst) begin
            bad++; $display("FAIL stall_pkt c%0d: got %h/%h want %h/%h", c, out_pc, out_inst, e.pc, e.inst);
          end
        end
      end
      @(posedge CLK); #1;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_hold();
    exp_q.delete();
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h20));
    exp_q.push_back(mk(32'h24));
    if (BYPASS) exp_q.push_back(mk(32'h28));
    out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      out_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      redirect_valid = (c == 4);
      redirect_pc = 32'h20;
      @(negedge CLK);
      if (c == 4) begin
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin bad++; $display("FAIL redir_kill: got %b %h want 0 0", out_valid, out_pc); end
        total++; if (imem_addr !== (BYPASS ? 32'h20 : 32'h8)) begin bad++; $display("FAIL redir_addr: got %h want %h", imem_addr, BYPASS ? 32'h20 : 32'h8); end
      end
      if (c == 5) begin
        total++; if (out_valid !== BYPASS) begin bad++; $display("FAIL redir_penalty: got valid=%b want %b", out_valid, BYPASS); end
        total++; if (imem_addr !== (BYPASS ? 32'h24 : 32'h20)) begin bad++; $display("FAIL redir_next_addr: got %h want %h", imem_addr, BYPASS ? 32'h24 : 32'h20); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL redir_extra: got pc=%h want no packet", out_pc); end
        else begin
          e = exp_q.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst) begin
            bad++; $display("FAIL redir_pkt c%0d: got %h/%h want %h/%h", c, out_pc, out_inst, e.pc, e.inst);
          end
        end
      end
      @(posedge CLK); #1;
    end
    redirect_valid = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL redir_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_misaligned();
    exp_q.delete();
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h20));
    exp_q.push_back(mk(32'h24));
    if (BYPASS) exp_q.push_back(mk(32'h28));
    out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      redirect_valid = (c == 3);
      redirect_pc = 32'h23;
      @(negedge CLK);
      if (c == 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mis_kill: got valid=%b want 0", out_valid); end
        total++; if (imem_addr !== (BYPASS ? 32'h20 : 32'hC)) begin bad++; $display("FAIL mis_addr: got %h want %h", imem_addr, BYPASS ? 32'h20 : 32'hC); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL mis_extra: got pc=%h want no packet", out_pc); end
        else begin
          e = exp_q.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst) begin
            bad++; $display("FAIL mis_pkt c%0d: got %h/%h want %h/%h", c, out_pc, out_inst, e.pc, e.inst);
          end
        end
      end
      @(posedge CLK); #1;
    end
    redirect_valid = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mis_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstall();
    exp_q.delete();
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h8));
    out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      RST = (c == 4);
      @(negedge CLK);
      if (c == 3) begin
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin bad++; $display("FAIL mrst_hold: got %b %h want 1 4", out_valid, out_pc); end
      end
      if (c == 5) begin
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin bad++; $display("FAIL mrst_drop: got %b %h want 0 0", out_valid, out_pc); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL mrst_addr: got %h want 0", imem_addr); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL mrst_extra: got pc=%h want no packet", out_pc); end
        else begin
          e = exp_q.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst) begin
            bad++; $display("FAIL mrst_pkt c%0d: got %h/%h want %h/%h", c, out_pc, out_inst, e.pc, e.inst);
          end
        end
      end
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mrst_missing: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_stream();
    test_stall();
    test_redirect_hold();
    test_redirect_misaligned();
    test_reset_midstall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
